bin2bcd_seq: RTL and testbench



---
 rtl/bcd_pkg.sv | 30 +++
 rtl/bcd_adj3.sv | 24 ++
 rtl/bin2bcd_seq.sv | 151 +++++++++++++++
 tb/tb_bin2bcd_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Purpose: shared types and constants for the sequential binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_e        - converter FSM state (IDLE / SHIFT / DONE), 2-bit encoding
//   BCD_ADJ_THRESH - a nibble at or above this value is corrected before shifting
//   BCD_ADJ_ADD    - correction added to such a nibble
//   bcd_digits()   - minimum decimal digits needed to show 2^bin_w-1
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Decimal digit count of 2^bin_w-1 is floor(bin_w*log10(2))+1, because a
  // power of two is never a power of ten. log10(2) ~= 0.30103 holds exactly
  // enough for any realistic width; longint keeps the product from overflowing.
  function automatic int bcd_digits(input int bin_w);
    longint l_prod;
    l_prod = longint'(bin_w) * 64'sd30103;
    return int'(l_prod / 64'sd100000) + 1;
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Purpose: one double-dabble correction step for a single BCD nibble (+3 when >=5).
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake.
//
// Ports:
//   i_nib - BCD nibble before correction
//   o_nib - nibble after correction, ready to be shifted left by one
module bcd_adj3
  import bcd_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  // A legal nibble is at most 9, so the corrected value is at most 12. It
  // fits in four bits, and no carry ever crosses into the next digit.
  always_comb begin
    o_nib = i_nib;
    if (i_nib >= BCD_ADJ_THRESH) begin
      o_nib = i_nib + BCD_ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Purpose: sequential binary-to-BCD converter (shift-and-add-3), one input bit per cycle.
// Latency: out_valid rises BIN_W cycles after the accepting edge; BIN_W+2 cycles per conversion.
// Backpressure: the result is held in DONE until out_ready; in_ready is high only in IDLE.
//
// Ports:
//   clk, rst_n         - clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready  - input handshake; in_data is sampled only on the accepting edge
//   in_data [BIN_W]    - unsigned binary value
//   out_valid/out_ready- output handshake
//   out_bcd [4*DIGITS] - packed BCD, units digit in [3:0]; keeps the last completed
//                        result until the next conversion finishes (no flicker downstream)
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  // The largest input must be representable, otherwise the top digit would
  // silently wrap.
  if (DIGITS < bcd_digits(BIN_W)) begin : g_digits_check
    $error("bin2bcd_seq: DIGITS=%0d too small for BIN_W=%0d (need %0d)",
           DIGITS, BIN_W, bcd_digits(BIN_W));
  end

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [BIN_W-1:0]   r_bin_sr;
  logic [BIN_W-1:0]   w_bin_shift;
  logic [BCD_W-1:0]   r_bcd_sr;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [BCD_W-1:0]   w_bcd_shift;
  logic [BCD_W-1:0]   r_out_bcd;
  logic               w_accept;
  logic               w_last;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Per-digit correction, applied to the BCD register before every shift.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .i_nib (r_bcd_sr[4*g +: 4]),
      .o_nib (w_bcd_adj[4*g +: 4])
    );
  end

  // {bcd, bin} shifts left as one long register: the MSB of the binary part
  // enters bit 0 of the BCD part. The bit shifted out of the top of the BCD
  // part is always zero when DIGITS is large enough, so it is simply dropped.
  assign {w_bcd_shift, w_bin_shift} = {w_bcd_adj, r_bin_sr} << 1;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. in_ready is deliberately low in DONE, so a new value is
  // never taken on the same edge that the result is handed off.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: counter, shift registers and the output holding register.
  // r_out_bcd is written only on the final shift, so partial results never
  // reach the display, and it keeps its value through IDLE and the next SHIFT.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_bin_sr  <= '0;
      r_bcd_sr  <= '0;
      r_out_bcd <= '0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_bin_sr <= in_data;
      r_bcd_sr <= '0;
    end else if (r_state == SHIFT) begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_bin_sr <= w_bin_shift;
      r_bcd_sr <= w_bcd_shift;
      if (w_last) begin
        r_out_bcd <= w_bcd_shift;
      end
    end
  end

  assign out_bcd = r_out_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_data;
  logic [11:0] out_bcd;
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] in_data16;
  logic [19:0] out_bcd16;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int stab_viol = 0;
  int acc_q[$];
  logic [11:0] prev_bcd;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .in_data   (in_data16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out_bcd   (out_bcd16)
  );

  // Edge counter and record of every input handshake on the 8-bit instance.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
  end

  // out_bcd may only change together with out_valid rising, or under reset.
  always @(negedge clk) begin
    if (rst_n && !out_valid && (prev_bcd !== out_bcd)) stab_viol++;
    prev_bcd = out_bcd;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int t;
    r = '0;
    t = v;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_bcd !== 12'h000) begin errors++; $display("FAIL reset_out_bcd: got %h expected 000", out_bcd); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
  endtask

  task automatic test_single_255();
    int early;
    early = 0;
    in_data = 8'd255; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_data = 8'd0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_in_ready_drop: got %b expected 0", in_ready); end
    for (int i = 1; i < 8; i++) begin
      tick();
      if (out_valid !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL single_early_valid: got %0d early cycles expected 0", early); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_at_8: got %b expected 1", out_valid); end
    checks++; if (out_bcd !== 12'h255) begin errors++; $display("FAIL single_bcd_255: got %h expected 255", out_bcd); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL single_back_idle: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    checks++; if (out_bcd !== 12'h255) begin errors++; $display("FAIL single_bcd_hold: got %h expected 255", out_bcd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vals [3];
    logic [11:0] exps [3];
    int n;
    vals = '{8'd0, 8'd99, 8'd100};
    exps = '{12'h000, 12'h099, 12'h100};
    acc_q.delete();
    out_ready = 1'b1; in_valid = 1'b1; in_data = vals[0];
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin tick(); n++; end while (!out_valid && n < 30);
      checks++; if (out_valid !== 1'b1 || out_bcd !== exps[k]) begin errors++; $display("FAIL b2b_result_%0d: valid=%b bcd=%h expected 1/%h", k, out_valid, out_bcd, exps[k]); end
      if (k < 2) in_data = vals[k+1];
      else       in_valid = 1'b0;
    end
    tick();
    checks++; if (acc_q.size() !== 3) begin errors++; $display("FAIL b2b_accept_count: got %0d expected 3", acc_q.size()); end
    if (acc_q.size() == 3) begin
      checks++; if (acc_q[1] - acc_q[0] !== 10) begin errors++; $display("FAIL b2b_spacing_01: got %0d expected 10", acc_q[1] - acc_q[0]); end
      checks++; if (acc_q[2] - acc_q[1] !== 10) begin errors++; $display("FAIL b2b_spacing_12: got %0d expected 10", acc_q[2] - acc_q[1]); end
    end
  endtask

  task automatic test_hold_37();
    int n;
    in_data = 8'd37; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!out_valid && n < 30);
    checks++; if (n !== 8) begin errors++; $display("FAIL hold_latency: got %0d expected 8", n); end
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'd99;
      checks++; if (out_valid !== 1'b1 || out_bcd !== 12'h037 || in_ready !== 1'b0) begin errors++; $display("FAIL hold_stall_%0d: valid=%b bcd=%h in_ready=%b expected 1/037/0", i, out_valid, out_bcd, in_ready); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b1 || out_bcd !== 12'h037) begin errors++; $display("FAIL hold_release: valid=%b bcd=%h expected 1/037", out_valid, out_bcd); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_done: valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    out_ready = 1'b1; in_data = 8'd200; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if (out_bcd !== 12'h000) begin errors++; $display("FAIL rstmid_bcd_clear: got %h expected 000", out_bcd); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_flags: valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0 || out_bcd !== 12'h000) begin errors++; $display("FAIL rstmid_no_valid: valid_cycles=%0d bcd=%h expected 0/000", seen, out_bcd); end
    in_data = 8'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!out_valid && n < 30);
    checks++; if (n !== 8 || out_bcd !== 12'h007) begin errors++; $display("FAIL rstmid_next_7: latency=%0d bcd=%h expected 8/007", n, out_bcd); end
    tick();
  endtask

  task automatic test_wide();
    int n;
    out_ready16 = 1'b1; in_data16 = 16'd65535; in_valid16 = 1'b1;
    tick();
    in_valid16 = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!out_valid16 && n < 40);
    checks++; if (n !== 16) begin errors++; $display("FAIL wide_latency: got %0d expected 16", n); end
    checks++; if (out_bcd16 !== 20'h65535) begin errors++; $display("FAIL wide_bcd: got %h expected 65535", out_bcd16); end
    tick();
    checks++; if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin errors++; $display("FAIL wide_back_idle: valid=%b in_ready=%b expected 0/1", out_valid16, in_ready16); end
  endtask

  task automatic test_exhaustive();
    int n;
    logic [19:0] full;
    logic [11:0] expv;
    out_ready = 1'b1;
    for (int v = 0; v < 256; v++) begin
      in_data = 8'(v); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!out_valid && n < 30);
      full = ref_bcd(v);
      expv = full[11:0];
      checks++; if (out_valid !== 1'b1 || out_bcd !== expv) begin errors++; $display("FAIL exh_%0d: valid=%b bcd=%h expected 1/%h", v, out_valid, out_bcd, expv); end
      for (int d = 0; d < 3; d++) begin
        checks++; if (out_bcd[4*d +: 4] > 4'd9) begin errors++; $display("FAIL exh_nibble_%0d_%0d: got %h expected <=9", v, d, out_bcd[4*d +: 4]); end
      end
      tick();
    end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL bcd_stable_without_valid: got %0d changes expected 0", stab_viol); end
  endtask

  initial begin
    test_reset();
    test_single_255();
    test_back_to_back();
    test_hold_37();
    test_reset_mid();
    test_wide();
    test_exhaustive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
